// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_FETCH = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_FETCH = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HW   = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b11;

endpackage

// File: rtl/mem_arb_timer.sv
// Access watchdog: counts cycles while enabled and flags the final allowed cycle.
module mem_arb_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic clr_in,
  input  logic en_in,
  output logic expire_out
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  // Cycle counter; clear has priority over enable.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_count <= '0;
    end else if (clr_in) begin
      r_count <= '0;
    end else if (en_in) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign expire_out = (r_count == LAST_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between instruction
// fetch and the data load/store path, with anti-starvation and a watchdog.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              if_req_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  output logic [DATA_W-1:0] if_rdata_out,
  output logic              if_ready_out,
  input  logic              dm_re_in,
  input  logic              dm_we_in,
  input  logic [ADDR_W-1:0] dm_addr_in,
  input  logic [DATA_W-1:0] dm_wdata_in,
  input  logic [1:0]        dm_size_in,
  output logic [DATA_W-1:0] dm_rdata_out,
  output logic              dm_ready_out,
  output logic              mem_req_out,
  output logic              mem_we_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [DATA_W-1:0] mem_wdata_out,
  output logic [1:0]        mem_size_out,
  input  logic              mem_ack_in,
  input  logic [DATA_W-1:0] mem_rdata_in,
  output logic              stall_out,
  output logic              bus_err_out
);

  arb_state_t       r_state;
  arb_state_t       w_state_nx;
  grant_t           r_last_grant;
  grant_t           w_grant;
  logic             w_grant_vld;
  logic             w_dm_pend;
  logic             w_if_pend;
  logic             w_busy;
  logic             w_expire;
  logic             w_done_ack;
  logic             w_done_to;

  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;
  logic              r_if_ready;
  logic              r_dm_ready;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [1:0]        r_mem_size;
  logic              r_bus_err;

  // A request in the same cycle as its own ready pulse is the old one still held.
  assign w_dm_pend  = (dm_re_in | dm_we_in) & ~r_dm_ready;
  assign w_if_pend  = if_req_in & ~r_if_ready;
  assign w_busy     = (r_state != ST_IDLE);
  assign w_done_ack = w_busy & mem_ack_in;
  assign w_done_to  = w_busy & ~mem_ack_in & w_expire;

  mem_arb_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .clr_in    (~w_busy | mem_ack_in | w_expire),
    .en_in     (w_busy),
    .expire_out(w_expire)
  );

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Grant decision and next state.
  always_comb begin
    w_state_nx  = r_state;
    w_grant     = GRANT_FETCH;
    w_grant_vld = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_dm_pend && (!w_if_pend || (r_last_grant == GRANT_FETCH))) begin
          w_grant_vld = 1'b1;
          w_grant     = GRANT_DATA;
          w_state_nx  = ST_DATA;
        end else if (w_if_pend) begin
          w_grant_vld = 1'b1;
          w_grant     = GRANT_FETCH;
          w_state_nx  = ST_FETCH;
        end else begin
          w_state_nx  = ST_IDLE;
        end
      end
      ST_DATA, ST_FETCH: begin
        if (mem_ack_in || w_expire) begin
          w_state_nx = ST_IDLE;
        end else begin
          w_state_nx = r_state;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // Memory-side request registers and requester completion registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_last_grant <= GRANT_FETCH;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_size   <= 2'b00;
      r_if_rdata   <= '0;
      r_dm_rdata   <= '0;
      r_if_ready   <= 1'b0;
      r_dm_ready   <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      r_if_ready <= 1'b0;
      r_dm_ready <= 1'b0;
      r_bus_err  <= 1'b0;
      if (w_grant_vld) begin
        r_mem_req    <= 1'b1;
        r_last_grant <= w_grant;
        if (w_grant == GRANT_DATA) begin
          r_mem_we    <= dm_we_in;
          r_mem_addr  <= dm_addr_in;
          r_mem_wdata <= dm_wdata_in;
          r_mem_size  <= dm_size_in;
        end else begin
          r_mem_we    <= 1'b0;
          r_mem_addr  <= if_addr_in;
          r_mem_wdata <= '0;
          r_mem_size  <= SIZE_WORD;
        end
      end else if (w_done_ack) begin
        r_mem_req <= 1'b0;
        if (r_state == ST_FETCH) begin
          r_if_ready <= 1'b1;
          r_if_rdata <= mem_rdata_in;
        end else begin
          r_dm_ready <= 1'b1;
          if (!r_mem_we) begin
            r_dm_rdata <= mem_rdata_in;
          end
        end
      end else if (w_done_to) begin
        r_mem_req <= 1'b0;
        r_bus_err <= 1'b1;
        if (r_state == ST_FETCH) begin
          r_if_ready <= 1'b1;
          r_if_rdata <= '0;
        end else begin
          r_dm_ready <= 1'b1;
          r_dm_rdata <= '0;
        end
      end
    end
  end

  assign if_rdata_out  = r_if_rdata;
  assign if_ready_out  = r_if_ready;
  assign dm_rdata_out  = r_dm_rdata;
  assign dm_ready_out  = r_dm_ready;
  assign mem_req_out   = r_mem_req;
  assign mem_we_out    = r_mem_we;
  assign mem_addr_out  = r_mem_addr;
  assign mem_wdata_out = r_mem_wdata;
  assign mem_size_out  = r_mem_size;
  assign bus_err_out   = r_bus_err;
  assign stall_out     = w_if_pend | w_dm_pend;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-vector bench for mem_port_arbiter; memory side driven by hand.
module tb_mem_port_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        if_req_in;
  logic [31:0] if_addr_in;
  logic [31:0] if_rdata_out;
  logic        if_ready_out;
  logic        dm_re_in;
  logic        dm_we_in;
  logic [31:0] dm_addr_in;
  logic [31:0] dm_wdata_in;
  logic [1:0]  dm_size_in;
  logic [31:0] dm_rdata_out;
  logic        dm_ready_out;
  logic        mem_req_out;
  logic        mem_we_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_wdata_out;
  logic [1:0]  mem_size_out;
  logic        mem_ack_in;
  logic [31:0] mem_rdata_in;
  logic        stall_out;
  logic        bus_err_out;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .if_req_in(if_req_in), .if_addr_in(if_addr_in),
    .if_rdata_out(if_rdata_out), .if_ready_out(if_ready_out),
    .dm_re_in(dm_re_in), .dm_we_in(dm_we_in), .dm_addr_in(dm_addr_in),
    .dm_wdata_in(dm_wdata_in), .dm_size_in(dm_size_in),
    .dm_rdata_out(dm_rdata_out), .dm_ready_out(dm_ready_out),
    .mem_req_out(mem_req_out), .mem_we_out(mem_we_out),
    .mem_addr_out(mem_addr_out), .mem_wdata_out(mem_wdata_out),
    .mem_size_out(mem_size_out), .mem_ack_in(mem_ack_in),
    .mem_rdata_in(mem_rdata_in), .stall_out(stall_out),
    .bus_err_out(bus_err_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n_in = 1'b0; if_req_in = 1'b0; if_addr_in = 32'h0;
    dm_re_in = 1'b0; dm_we_in = 1'b0; dm_addr_in = 32'h0;
    dm_wdata_in = 32'h0; dm_size_in = 2'b11;
    mem_ack_in = 1'b0; mem_rdata_in = 32'h0;
    tick(); tick();
    chk("rst_mem_req", 32'(mem_req_out), 32'h0);
    chk("rst_mem_addr", mem_addr_out, 32'h0);
    chk("rst_if_ready", 32'(if_ready_out), 32'h0);
    chk("rst_dm_ready", 32'(dm_ready_out), 32'h0);
    chk("rst_bus_err", 32'(bus_err_out), 32'h0);
    chk("rst_stall", 32'(stall_out), 32'h0);
    rst_n_in = 1'b1;
    tick();

    // 1: fetch only, minimum latency
    if_req_in = 1'b1; if_addr_in = 32'h0040_0000;
    #1 chk("t1_stall_req", 32'(stall_out), 32'h1);
    tick();
    chk("t1_mem_req", 32'(mem_req_out), 32'h1);
    chk("t1_mem_addr", mem_addr_out, 32'h0040_0000);
    chk("t1_mem_we", 32'(mem_we_out), 32'h0);
    chk("t1_mem_size", 32'(mem_size_out), 32'h3);
    chk("t1_stall_wait", 32'(stall_out), 32'h1);
    mem_ack_in = 1'b1; mem_rdata_in = 32'h2008_0005;
    tick();
    chk("t1_if_ready", 32'(if_ready_out), 32'h1);
    chk("t1_if_rdata", if_rdata_out, 32'h2008_0005);
    chk("t1_mem_req_drop", 32'(mem_req_out), 32'h0);
    chk("t1_stall_ready", 32'(stall_out), 32'h0);
    mem_ack_in = 1'b0; if_req_in = 1'b0;
    tick();
    chk("t1_if_ready_pulse", 32'(if_ready_out), 32'h0);
    chk("t1_no_reissue", 32'(mem_req_out), 32'h0);

    // 2: simultaneous pair, data first (last grant was fetch)
    if_req_in = 1'b1; if_addr_in = 32'h0000_0100;
    dm_re_in = 1'b1; dm_addr_in = 32'h1000_0000; dm_size_in = 2'b11;
    tick();
    chk("t2_first_addr", mem_addr_out, 32'h1000_0000);
    chk("t2_first_we", 32'(mem_we_out), 32'h0);
    mem_ack_in = 1'b1; mem_rdata_in = 32'h1111_2222;
    tick();
    chk("t2_dm_ready", 32'(dm_ready_out), 32'h1);
    chk("t2_dm_rdata", dm_rdata_out, 32'h1111_2222);
    chk("t2_stall_fetch_pend", 32'(stall_out), 32'h1);
    mem_ack_in = 1'b0; dm_re_in = 1'b0;
    tick();
    chk("t2_second_req", 32'(mem_req_out), 32'h1);
    chk("t2_second_addr", mem_addr_out, 32'h0000_0100);
    mem_ack_in = 1'b1; mem_rdata_in = 32'h3333_4444;
    tick();
    chk("t2_if_rdata", if_rdata_out, 32'h3333_4444);
    mem_ack_in = 1'b0; if_req_in = 1'b0;
    tick();
    // lone load makes data the last grant
    dm_re_in = 1'b1; dm_addr_in = 32'h1000_0010;
    tick();
    chk("t2_lone_addr", mem_addr_out, 32'h1000_0010);
    mem_ack_in = 1'b1; mem_rdata_in = 32'h5555_6666;
    tick();
    chk("t2_lone_rdata", dm_rdata_out, 32'h5555_6666);
    mem_ack_in = 1'b0; dm_re_in = 1'b0;
    tick();
    // second pair goes fetch first
    if_req_in = 1'b1; if_addr_in = 32'h0000_0104;
    dm_re_in = 1'b1; dm_addr_in = 32'h1000_0020;
    tick();
    chk("t2b_first_addr", mem_addr_out, 32'h0000_0104);
    mem_ack_in = 1'b1; mem_rdata_in = 32'h7777_8888;
    tick();
    chk("t2b_if_rdata", if_rdata_out, 32'h7777_8888);
    mem_ack_in = 1'b0; if_req_in = 1'b0;
    tick();
    chk("t2b_second_addr", mem_addr_out, 32'h1000_0020);
    mem_ack_in = 1'b1; mem_rdata_in = 32'h9999_AAAA;
    tick();
    chk("t2b_dm_rdata", dm_rdata_out, 32'h9999_AAAA);
    mem_ack_in = 1'b0; dm_re_in = 1'b0;
    tick();

    // 3: byte store with 3 wait cycles; address change mid-access is ignored
    dm_we_in = 1'b1; dm_size_in = 2'b00; dm_addr_in = 32'h1000_0003;
    dm_wdata_in = 32'h0000_00AB;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("t3_mem_req", 32'(mem_req_out), 32'h1);
      chk("t3_mem_we", 32'(mem_we_out), 32'h1);
      chk("t3_mem_size", 32'(mem_size_out), 32'h0);
      chk("t3_mem_addr", mem_addr_out, 32'h1000_0003);
      chk("t3_mem_wdata", mem_wdata_out, 32'h0000_00AB);
      if (i == 2) dm_addr_in = 32'h2000_0000;
      if (i == 4) begin
        mem_ack_in = 1'b1; mem_rdata_in = 32'hDEAD_BEEF;
      end
    end
    tick();
    chk("t3_dm_ready", 32'(dm_ready_out), 32'h1);
    chk("t3_dm_rdata_kept", dm_rdata_out, 32'h9999_AAAA);
    chk("t3_mem_req_drop", 32'(mem_req_out), 32'h0);
    mem_ack_in = 1'b0; dm_we_in = 1'b0; dm_size_in = 2'b11;
    tick();
    chk("t3_dm_ready_pulse", 32'(dm_ready_out), 32'h0);

    // 4: fetch timeout after 16 request cycles
    if_req_in = 1'b1; if_addr_in = 32'h0000_0200;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("t4_mem_req_held", 32'(mem_req_out), 32'h1);
      chk("t4_no_err_yet", 32'(bus_err_out), 32'h0);
    end
    tick();
    chk("t4_mem_req_drop", 32'(mem_req_out), 32'h0);
    chk("t4_if_ready", 32'(if_ready_out), 32'h1);
    chk("t4_if_rdata_zero", if_rdata_out, 32'h0);
    chk("t4_bus_err", 32'(bus_err_out), 32'h1);
    if_req_in = 1'b0;
    tick();
    chk("t4_bus_err_pulse", 32'(bus_err_out), 32'h0);
    chk("t4_idle", 32'(mem_req_out), 32'h0);

    // 5: ack on the last allowed cycle wins over timeout
    if_req_in = 1'b1; if_addr_in = 32'h0000_0300;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("t5_mem_req_held", 32'(mem_req_out), 32'h1);
      if (i == 16) begin
        mem_ack_in = 1'b1; mem_rdata_in = 32'h5A5A_5A5A;
      end
    end
    tick();
    chk("t5_if_ready", 32'(if_ready_out), 32'h1);
    chk("t5_if_rdata", if_rdata_out, 32'h5A5A_5A5A);
    chk("t5_no_bus_err", 32'(bus_err_out), 32'h0);
    mem_ack_in = 1'b0; if_req_in = 1'b0;
    tick();
    chk("t5_no_bus_err_after", 32'(bus_err_out), 32'h0);

    // 6: reset in the middle of a data access, fetch waiting behind it
    if_req_in = 1'b1; if_addr_in = 32'h0000_0400;
    dm_re_in = 1'b1; dm_addr_in = 32'h1000_0040;
    tick(); tick(); tick();
    chk("t6_data_busy", mem_addr_out, 32'h1000_0040);
    chk("t6_req_busy", 32'(mem_req_out), 32'h1);
    rst_n_in = 1'b0; dm_re_in = 1'b0;
    #1;
    chk("t6_rst_mem_req", 32'(mem_req_out), 32'h0);
    chk("t6_rst_mem_addr", mem_addr_out, 32'h0);
    chk("t6_rst_mem_size", 32'(mem_size_out), 32'h0);
    chk("t6_rst_dm_rdata", dm_rdata_out, 32'h0);
    chk("t6_rst_if_rdata", if_rdata_out, 32'h0);
    tick();
    rst_n_in = 1'b1;
    tick();
    chk("t6_fetch_req", 32'(mem_req_out), 32'h1);
    chk("t6_fetch_addr", mem_addr_out, 32'h0000_0400);
    mem_ack_in = 1'b1; mem_rdata_in = 32'h0BAD_F00D;
    tick();
    chk("t6_if_ready", 32'(if_ready_out), 32'h1);
    chk("t6_if_rdata", if_rdata_out, 32'h0BAD_F00D);
    mem_ack_in = 1'b0; if_req_in = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
